// File: rtl/tmds_pll_ctrl.sv
// Reset/lock sequencer for the HDMI TMDS PLL: pulses PLL reset, qualifies LOCK, releases pixel reset.
// Define TMDS_PLL_CTRL_LOSS_CNT_EN to add the saturating lock-loss counter output loss_cnt.
module tmds_pll_ctrl #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TIMEOUT = 50000,
   parameter int LOCK_STABLE  = 1024,
   parameter int MAX_RETRY    = 3
) (
   input  logic       clkin,
   input  logic       reset,
   input  logic       lock,
   input  logic       restart,
   output logic       pll_reset,
   output logic       hdmi_rst,
   output logic       locked_ok,
   output logic       fail,
   output logic [2:0] state
`ifdef TMDS_PLL_CTRL_LOSS_CNT_EN
   ,
   output logic [7:0] loss_cnt
`endif
);

   // One shared phase counter; only one phase timer is ever live at a time.
   localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int CNT_MAX   = ((CNT_MAX_A > LOCK_STABLE) ? CNT_MAX_A : LOCK_STABLE) - 1;
   localparam int CNT_W     = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam int RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STB_LAST   = CNT_W'(LOCK_STABLE - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_WAIT   = 3'd1,
      S_STABLE = 3'd2,
      S_RUN    = 3'd3,
      S_FAIL   = 3'd4
   } state_t;

   state_t             st, st_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [RETRY_W-1:0] retry, retry_n;
   logic [1:0]         lock_pipe;
   logic               lock_s;

   assign lock_s = lock_pipe[1];
   assign state  = st;

   always_ff @(posedge clkin) begin
      if (reset) begin
         st        <= S_RESET;
         cnt       <= '0;
         retry     <= '0;
         lock_pipe <= '0;
         pll_reset <= 1'b1;
         hdmi_rst  <= 1'b1;
         locked_ok <= 1'b0;
         fail      <= 1'b0;
      end else begin
         st        <= st_n;
         cnt       <= cnt_n;
         retry     <= retry_n;
         lock_pipe <= {lock_pipe[0], lock};
         // Outputs decoded from the next state so they change on the transition edge.
         pll_reset <= (st_n == S_RESET) || (st_n == S_FAIL);
         hdmi_rst  <= (st_n != S_RUN);
         locked_ok <= (st_n == S_RUN);
         fail      <= (st_n == S_FAIL);
      end
   end

   always_comb begin
      st_n    = st;
      cnt_n   = cnt;
      retry_n = retry;
      if (restart) begin
         st_n    = S_RESET;
         cnt_n   = '0;
         retry_n = '0;
      end else begin
         unique case (st)
            S_RESET: begin
               if (cnt == RST_LAST) begin
                  st_n  = S_WAIT;
                  cnt_n = '0;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            S_WAIT: begin
               if (lock_s) begin
                  st_n  = S_STABLE;
                  cnt_n = '0;
               end else if (cnt == TO_LAST) begin
                  cnt_n = '0;
                  if (retry == RETRY_LAST) begin
                     st_n = S_FAIL;
                  end else begin
                     st_n    = S_RESET;
                     retry_n = retry + RETRY_W'(1);
                  end
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            S_STABLE: begin
               // A dropout only restarts qualification; it is not a timeout.
               if (!lock_s) begin
                  st_n  = S_WAIT;
                  cnt_n = '0;
               end else if (cnt == STB_LAST) begin
                  st_n    = S_RUN;
                  cnt_n   = '0;
                  retry_n = '0;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            S_RUN: begin
               if (!lock_s) begin
                  st_n  = S_RESET;
                  cnt_n = '0;
               end
            end
            S_FAIL: begin
               st_n = S_FAIL;
            end
            default: begin
               st_n    = S_RESET;
               cnt_n   = '0;
               retry_n = '0;
            end
         endcase
      end
   end

`ifdef TMDS_PLL_CTRL_LOSS_CNT_EN
   // Only genuine lock loss in RUN counts; restart takes priority and is not a loss.
   logic loss_ev;
   assign loss_ev = !restart && (st == S_RUN) && !lock_s;

   always_ff @(posedge clkin) begin
      if (reset) begin
         loss_cnt <= '0;
      end else if (loss_ev && (loss_cnt != 8'hFF)) begin
         loss_cnt <= loss_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tmds_pll_ctrl.sv
// Self-checking bench for tmds_pll_ctrl: directed scenarios plus random lock/restart traffic
// compared every cycle against a phase-duration reference model.
module tb_tmds_pll_ctrl;

   localparam int RSTC = 4;
   localparam int TO   = 20;
   localparam int STB  = 8;
   localparam int MAXR = 2;

   logic       clkin = 1'b0;
   logic       reset = 1'b1;
   logic       lock = 1'b0;
   logic       restart = 1'b0;
   logic       pll_reset, hdmi_rst, locked_ok, fail;
   logic [2:0] state;
`ifdef TMDS_PLL_CTRL_LOSS_CNT_EN
   logic [7:0] loss_cnt;
`endif

   tmds_pll_ctrl #(
      .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TO), .LOCK_STABLE(STB), .MAX_RETRY(MAXR)
   ) dut (
      .clkin(clkin), .reset(reset), .lock(lock), .restart(restart),
      .pll_reset(pll_reset), .hdmi_rst(hdmi_rst), .locked_ok(locked_ok),
      .fail(fail), .state(state)
`ifdef TMDS_PLL_CTRL_LOSS_CNT_EN
      , .loss_cnt(loss_cnt)
`endif
   );

   always #5 clkin = ~clkin;

   int checks = 0;
   int errors = 0;

   // Reference: phase number, edges spent in the phase, timeouts so far, lock sample history.
   int m_ph = 0;
   int m_age = 0;
   int m_tries = 0;
   int m_loss = 0;
   int hist[2] = '{0, 0};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic rst, input logic lk, input logic rs);
      int ls;
      if (rst) begin
         m_ph = 0; m_age = 0; m_tries = 0; m_loss = 0; hist = '{0, 0};
         return;
      end
      ls = hist[1];
      hist[1] = hist[0];
      hist[0] = int'(lk);
      if (rs) begin
         m_ph = 0; m_age = 0; m_tries = 0;
         return;
      end
      m_age++;
      case (m_ph)
         0: if (m_age == RSTC) begin m_ph = 1; m_age = 0; end
         1: begin
            if (ls == 1) begin m_ph = 2; m_age = 0; end
            else if (m_age == TO) begin
               m_age = 0;
               if (m_tries == MAXR) m_ph = 4;
               else begin m_tries++; m_ph = 0; end
            end
         end
         2: begin
            if (ls == 0) begin m_ph = 1; m_age = 0; end
            else if (m_age == STB) begin m_ph = 3; m_age = 0; m_tries = 0; end
         end
         3: if (ls == 0) begin
               m_ph = 0; m_age = 0;
               if (m_loss < 255) m_loss++;
            end
         default: ;
      endcase
   endtask

   task automatic cyc(input logic lk, input logic rs);
      lock = lk;
      restart = rs;
      @(posedge clkin);
      model_edge(reset, lk, rs);
      #1;
      restart = 1'b0;
      check("state", 32'(state), 32'(m_ph));
      check("pll_reset", 32'(pll_reset), 32'(m_ph == 0 || m_ph == 4));
      check("hdmi_rst", 32'(hdmi_rst), 32'(m_ph != 3));
      check("locked_ok", 32'(locked_ok), 32'(m_ph == 3));
      check("fail", 32'(fail), 32'(m_ph == 4));
`ifdef TMDS_PLL_CTRL_LOSS_CNT_EN
      check("loss_cnt", 32'(loss_cnt), 32'(m_loss));
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, att, prev, kw;
      bit saw_wait;
`ifdef TMDS_PLL_CTRL_LOSS_CNT_EN
      int loss_before;
`endif

      // Reset values
      reset = 1'b1;
      repeat (3) cyc(1'b0, 1'b0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_pll", 32'(pll_reset), 32'd1);
      check("rst_hdmi", 32'(hdmi_rst), 32'd1);
      reset = 1'b0;

      // pll_reset held RST_CYCLES after release, then lock rises 10 cycles after release
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b0); n++;
         if (pll_reset == 1'b0) break;
      end
      check("pll_rst_len", 32'(n), 32'(RSTC));
      repeat (10 - RSTC) cyc(1'b0, 1'b0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 1'b0); n++;
         if (hdmi_rst == 1'b0) break;
      end
      check("lock_to_run", 32'(n - 1), 32'(2 + STB));
      check("run_state", 32'(state), 32'd3);
      check("run_ok", 32'(locked_ok), 32'd1);

      // Lock loss in RUN
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b0); n++;
         if (state == 3'd0) break;
      end
      check("drop_edges", 32'(n), 32'd3);
      check("drop_hdmi", 32'(hdmi_rst), 32'd1);
`ifdef TMDS_PLL_CTRL_LOSS_CNT_EN
      check("loss_first", 32'(loss_cnt), 32'd1);
`endif

      // Lock never comes: MAX_RETRY+1 attempts then FAIL
      att = 0; prev = int'(state);
      for (int i = 0; i < 300; i++) begin
         cyc(1'b0, 1'b0);
         if (state == 3'd1 && prev != 1) att++;
         prev = int'(state);
         if (state == 3'd4) break;
      end
      check("attempts", 32'(att), 32'(MAXR + 1));
      check("fail_flag", 32'(fail), 32'd1);
      check("fail_pll", 32'(pll_reset), 32'd1);
      repeat (5) cyc(1'b1, 1'b0);
      check("fail_hold", 32'(state), 32'd4);
      cyc(1'b1, 1'b1);
      check("restart_state", 32'(state), 32'd0);
      check("restart_fail", 32'(fail), 32'd0);

      // One-cycle glitch during qualification restarts the stable window
      for (int i = 0; i < 60; i++) begin
         cyc(1'b1, 1'b0);
         if (state == 3'd2) break;
      end
      repeat (3) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      saw_wait = 1'b0; kw = 0; n = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 1'b0); n++;
         if (state == 3'd1 && !saw_wait) begin saw_wait = 1'b1; kw = n; end
         if (state == 3'd3) break;
      end
      check("glitch_wait", 32'(saw_wait), 32'd1);
      check("glitch_run", 32'(n - kw), 32'(1 + STB));

      // Restart coincides with lock loss seen in RUN
`ifdef TMDS_PLL_CTRL_LOSS_CNT_EN
      loss_before = int'(loss_cnt);
`endif
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      check("rs_loss_state", 32'(state), 32'd0);
`ifdef TMDS_PLL_CTRL_LOSS_CNT_EN
      check("rs_loss_cnt", 32'(loss_cnt), 32'(loss_before));
`endif
      n = 1;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b0);
         if (state != 3'd0) break;
         n++;
      end
      check("rs_rst_len", 32'(n), 32'(RSTC));

      // Reset in the middle of WAIT_LOCK
      cyc(1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b0);
         if (state == 3'd1) break;
      end
      repeat (3) cyc(1'b0, 1'b0);
      reset = 1'b1;
      cyc(1'b0, 1'b0);
      check("midrst_state", 32'(state), 32'd0);
      check("midrst_pll", 32'(pll_reset), 32'd1);
      check("midrst_hdmi", 32'(hdmi_rst), 32'd1);
      check("midrst_ok", 32'(locked_ok), 32'd0);
      check("midrst_fail", 32'(fail), 32'd0);
      reset = 1'b0;

`ifdef TMDS_PLL_CTRL_LOSS_CNT_EN
      // Saturation after many losses
      for (int j = 0; j < 260; j++) begin
         for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0);
            if (state == 3'd3) break;
         end
         for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0);
            if (state == 3'd0) break;
         end
      end
      check("loss_sat", 32'(loss_cnt), 32'd255);
`endif

      // Random lock bursts with occasional restart/reset
      begin
         int hold;
         logic lv;
         hold = 0; lv = 1'b0;
         for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
               lv = ($urandom_range(0, 3) != 0);
               hold = int'($urandom_range(1, 30));
            end
            hold--;
            reset = ($urandom_range(0, 299) == 0);
            cyc(lv, $urandom_range(0, 63) == 0);
         end
         reset = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
